// File: rtl/cdc_pkg.sv
// Types and helpers shared by the req/ack CDC channel controllers (sender now, receiver later).
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } cdc_tx_state_t;

    // Bits needed to hold 0..max_val inclusive; never less than one bit.
    function automatic int tmo_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, DEPTH a power of 2: head is valid combinationally whenever !empty.
// Latency: a push is visible at head one edge later; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // The extra pointer MSB distinguishes full from empty when the index bits match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/cdc_hs_sender.sv
// Source-side 4-phase req/ack controller: buffers stream words and sends each with data held for the whole handshake.
// Latency: word into empty FIFO at edge E0 drives req/data after E1; in_ready drops only when the FIFO is full.
module cdc_hs_sender
    import cdc_pkg::*;
#(
    parameter int W       = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int CW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          req,
    input  logic          ack,
    output logic [W-1:0]  data,
    output logic          busy,
    output logic [CW-1:0] xfer_cnt,
    output logic          timeout_err
);

    localparam int TW = tmo_width(TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_ONE = TW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    cdc_tx_state_t state;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [W-1:0]  fifo_head;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_cnt_nxt;

    assign in_ready    = !fifo_full;
    // A stale ack from a far side still leaving reset must not start a new handshake.
    assign fifo_pop    = (state == IDLE) && !fifo_empty && !ack;
    assign busy        = (state != IDLE) || !fifo_empty;
    assign tmo_cnt_nxt = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TMO_ONE;

    sync_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .push_dat (in_data),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req         <= 1'b0;
            data        <= '0;
            tmo_cnt     <= '0;
            xfer_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        data    <= fifo_head;
                        req     <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        req   <= 1'b0;
                        state <= RELEASE;
                    end else begin
                        // Timeout only flags the stall; the handshake keeps waiting for ack.
                        tmo_cnt <= tmo_cnt_nxt;
                        if ((TIMEOUT != 0) && (tmo_cnt_nxt == TMO_MAX)) timeout_err <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!ack) begin
                        xfer_cnt <= xfer_cnt + CNT_ONE;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_hs_sender.sv
// Bench for cdc_hs_sender: directed table, multi-cycle corner sequences and a randomized scoreboard run.
module tb_cdc_hs_sender;

    localparam int W       = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int CW      = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          req;
    logic          ack;
    logic [W-1:0]  data;
    logic          busy;
    logic [CW-1:0] xfer_cnt;
    logic          timeout_err;

    logic resp_en;
    logic ack_man;
    logic rnd_mode;
    logic ack_auto = 1'b0;
    int   ack_dly_cfg;
    int   rel_dly_cfg;

    int checks = 0;
    int errors = 0;
    int exp_cnt;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] wdat;
        int           ack_dly;
        int           rel_dly;
        logic [W-1:0] exp_dat;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    assign ack = resp_en ? ack_auto : ack_man;

    cdc_hs_sender #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .req         (req),
        .ack         (ack),
        .data        (data),
        .busy        (busy),
        .xfer_cnt    (xfer_cnt),
        .timeout_err (timeout_err)
    );

    // Far-side responder: raise ack some cycles after req, drop it some cycles after req falls.
    int r_cnt = 0;
    int r_ack_rnd = 0;
    int r_rel_rnd = 0;
    always @(negedge clk) begin
        if (!resp_en || rst) begin
            ack_auto = 1'b0;
            r_cnt    = 0;
        end else if (!ack_auto && req) begin
            if (r_cnt >= (rnd_mode ? r_ack_rnd : ack_dly_cfg)) begin
                ack_auto = 1'b1;
                r_cnt    = 0;
            end else r_cnt++;
        end else if (ack_auto && !req) begin
            if (r_cnt >= (rnd_mode ? r_rel_rnd : rel_dly_cfg)) begin
                ack_auto  = 1'b0;
                r_cnt     = 0;
                r_ack_rnd = $urandom_range(0, 4);
                r_rel_rnd = $urandom_range(0, 3);
            end else r_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        int   n;
        logic acc;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        do begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end while (!acc && n < 500);
        in_valid = 1'b0;
        if (!acc) chk("push_accept", 64'(acc), 64'(1));
    endtask

    task automatic wait_req(input logic val, input string nm);
        for (int i = 0; i < 100 && req !== val; i++) step();
        chk(nm, 64'(req), 64'(val));
    endtask

    task automatic wait_idle(input int limit, input string nm);
        for (int i = 0; i < limit && (busy || req || ack); i++) step();
        chk(nm, 64'(busy || req || ack), 64'(0));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step();
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        ack_man     = 1'b1;
        resp_en     = 1'b0;
        rnd_mode    = 1'b0;
        ack_dly_cfg = 0;
        rel_dly_cfg = 0;
        exp_cnt     = 0;

        vecs[0] = '{wdat: 16'hA5A5, ack_dly: 3, rel_dly: 2, exp_dat: 16'hA5A5};
        vecs[1] = '{wdat: 16'hFFFF, ack_dly: 0, rel_dly: 0, exp_dat: 16'hFFFF};
        vecs[2] = '{wdat: 16'h0000, ack_dly: 1, rel_dly: 4, exp_dat: 16'h0000};
        vecs[3] = '{wdat: 16'h8001, ack_dly: 5, rel_dly: 1, exp_dat: 16'h8001};

        // Scoreboard: record accepted words, compare each word as req rises, police data stability.
        fork
            begin : monitor
                logic         prev_req;
                logic         prev_rst;
                logic [W-1:0] prev_data;
                prev_req  = 1'b0;
                prev_rst  = 1'b1;
                prev_data = '0;
                forever begin
                    @(negedge clk);
                    if (!prev_rst) begin
                        chk("data_stable", 64'((data !== prev_data) && !(req && !prev_req)), 64'(0));
                        if (req && !prev_req) begin
                            if (exp_q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_word got %0h expected none at %0t", data, $time);
                            end else begin
                                chk("word_order", 64'(data), 64'(exp_q.pop_front()));
                            end
                        end
                    end
                    if (rst) exp_q.delete();
                    else if (in_valid && in_ready) exp_q.push_back(in_data);
                    prev_req  = req;
                    prev_rst  = rst;
                    prev_data = data;
                end
            end
        join_none

        // Reset with stale ack held high.
        repeat (3) step();
        chk("rst_req", 64'(req), 64'(0));
        chk("rst_data", 64'(data), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_xfer_cnt", 64'(xfer_cnt), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_timeout_err", 64'(timeout_err), 64'(0));
        rst = 1'b0;
        push_word(16'h1234);
        repeat (5) step();
        chk("stale_ack_hold_req", 64'(req), 64'(0));
        chk("stale_ack_busy", 64'(busy), 64'(1));
        ack_man = 1'b0;
        step();
        chk("stale_ack_release_req", 64'(req), 64'(1));
        chk("stale_ack_release_data", 64'(data), 64'(16'h1234));
        ack_man = 1'b1;
        wait_req(1'b0, "stale_ack_req_fall");
        ack_man = 1'b0;
        wait_idle(50, "stale_ack_drain");
        exp_cnt++;
        chk("stale_ack_xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));

        // Single-word table with varying responder timing.
        resp_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ack_dly_cfg = vecs[i].ack_dly;
            rel_dly_cfg = vecs[i].rel_dly;
            push_word(vecs[i].wdat);
            chk("single_req_e0", 64'(req), 64'(0));
            step();
            chk("single_req_e1", 64'(req), 64'(1));
            chk("single_data_e1", 64'(data), 64'(vecs[i].exp_dat));
            wait_idle(100, "single_drain");
            exp_cnt++;
            chk("single_xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));
            chk("single_data_hold", 64'(data), 64'(vecs[i].exp_dat));
        end

        // Burst of six into a four-deep FIFO with a slow responder.
        ack_dly_cfg = 5;
        rel_dly_cfg = 3;
        for (int i = 1; i <= 6; i++) begin
            push_word(W'(i));
            if (i == 5) chk("burst_full_in_ready", 64'(in_ready), 64'(0));
        end
        wait_idle(300, "burst_drain");
        exp_cnt += 6;
        chk("burst_xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));
        chk("burst_queue_empty", 64'(exp_q.size()), 64'(0));

        // Timeout: ack withheld for 20 REQ cycles.
        resp_en = 1'b0;
        ack_man = 1'b0;
        apply_reset();
        push_word(16'hBEEF);
        step();
        chk("tmo_req", 64'(req), 64'(1));
        repeat (7) step();
        chk("tmo_before_8", 64'(timeout_err), 64'(0));
        step();
        chk("tmo_at_8", 64'(timeout_err), 64'(1));
        repeat (12) step();
        chk("tmo_sticky", 64'(timeout_err), 64'(1));
        chk("tmo_still_req", 64'(req), 64'(1));
        ack_man = 1'b1;
        wait_req(1'b0, "tmo_req_fall");
        ack_man = 1'b0;
        wait_idle(50, "tmo_drain");
        exp_cnt++;
        chk("tmo_xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));
        chk("tmo_sticky_after", 64'(timeout_err), 64'(1));

        // Reset in REQ with two words queued.
        apply_reset();
        chk("mid_rst_tmo_clear", 64'(timeout_err), 64'(0));
        push_word(16'h0A0A);
        push_word(16'h0B0B);
        push_word(16'h0C0C);
        chk("mid_rst_in_req", 64'(req), 64'(1));
        rst = 1'b1;
        step();
        rst     = 1'b0;
        exp_cnt = 0;
        chk("mid_rst_req", 64'(req), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_xfer_cnt", 64'(xfer_cnt), 64'(0));
        begin
            logic saw_req;
            saw_req = 1'b0;
            repeat (20) begin
                step();
                saw_req = saw_req | req;
            end
            chk("mid_rst_no_stale", 64'(saw_req), 64'(0));
        end

        // Randomized stress with scoreboard ordering.
        resp_en  = 1'b1;
        rnd_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) step();
            push_word(W'($urandom));
        end
        wait_idle(300, "stress_drain");
        exp_cnt += 1000;
        chk("stress_xfer_cnt", 64'(xfer_cnt), 64'(exp_cnt));
        chk("stress_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
